// File: rtl/riscv_ex_md_pkg.sv
// Shared constants for the riscv_ex_md execute stage: M-extension sub-ops, branch
// sub-ops, MD FSM states, forwarding selects, ALU operations and PC source codes.
package riscv_ex_md_pkg;

    localparam logic [2:0] FUNCT3_MD_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MD_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MD_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MD_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_MD_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_MD_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_MD_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_MD_REMU   = 3'b111;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int unsigned FWD_SEL_RF  = 0;
    localparam int unsigned FWD_SEL_WB  = 1;
    localparam int unsigned FWD_SEL_MEM = 2;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    localparam logic [1:0] PC_SRC_PC4  = 2'b00;
    localparam logic [1:0] PC_SRC_IMM  = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    // Divide ops have funct3[2] set; all others are multiplies.
    function automatic logic md_is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/riscv_ex_md_md_unit.sv
// Iterative radix-2 multiply/divide unit with IDLE/BUSY/DONE FSM and sign fix-up.
// RISCV_EX_FAST_MUL_EN selects a single-cycle combinational multiply path.
module riscv_ex_md_md_unit
    import riscv_ex_md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    md_state_e           r_state, w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_hi, r_lo, r_b;
    logic [2:0]          r_f3;
    logic                r_neg_q, r_neg_r;

    logic                w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic                w_div0, w_ovf, w_fast, w_special;
    logic [XLEN-1:0]     w_a_mag, w_b_mag;
    logic [XLEN:0]       w_mul_sum, w_div_sh, w_div_diff;
    logic [2*XLEN-1:0]   w_prod_res;

    // Operand signedness: MULHSU treats only rs1 as signed, MULHU/DIVU/REMU neither.
    assign w_is_div = md_is_div(i_funct3);
    assign w_a_sgn  = w_is_div ? ~i_funct3[0] : (i_funct3 != FUNCT3_MD_MULHU);
    assign w_b_sgn  = w_is_div ? ~i_funct3[0] : ~i_funct3[1];
    assign w_a_neg  = w_a_sgn & i_a[XLEN-1];
    assign w_b_neg  = w_b_sgn & i_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;
    assign w_div0   = w_is_div & (i_b == '0);
    assign w_ovf    = w_is_div & ~i_funct3[0] & (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_b);

`ifdef RISCV_EX_FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod;
    assign w_fast = ~w_is_div;
    assign w_prod = (2*XLEN)'(w_a_mag) * (2*XLEN)'(w_b_mag);
`else
    assign w_fast = 1'b0;
`endif
    assign w_special = w_div0 | w_ovf | w_fast;

    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_b};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= MD_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (i_start) w_next_state = w_special ? MD_DONE : MD_BUSY;
                MD_BUSY: if (r_cnt == CNT_W'(XLEN-1)) w_next_state = MD_DONE;
                MD_DONE: w_next_state = MD_IDLE;
                default: w_next_state = MD_IDLE;
            endcase
        end
    end

    always_comb begin
        o_stall = 1'b0;
        o_done  = 1'b0;
        o_busy  = (r_state != MD_IDLE);
        case (r_state)
            MD_IDLE: o_stall = i_start & ~i_flush;
            MD_BUSY: o_stall = ~i_flush;
            MD_DONE: o_done  = ~i_flush;
            default: ;
        endcase
    end

    // Special cases preload the final answer with sign flags clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_f3    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == MD_IDLE && i_start && !i_flush) begin
            r_cnt   <= '0;
            r_f3    <= i_funct3;
            r_b     <= w_b_mag;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            if (w_div0) begin
                r_hi <= i_a;
                r_lo <= '1;
            end else if (w_ovf) begin
                r_hi <= '0;
                r_lo <= i_a;
`ifdef RISCV_EX_FAST_MUL_EN
            end else if (w_fast) begin
                {r_hi, r_lo} <= w_prod;
                r_neg_q      <= w_a_neg ^ w_b_neg;
`endif
            end else begin
                r_hi    <= '0;
                r_lo    <= w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end else if (r_state == MD_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (md_is_div(r_f3)) begin
                r_hi <= w_div_diff[XLEN] ? w_div_sh[XLEN-1:0] : w_div_diff[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
            end else begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign w_prod_res = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};

    always_comb begin
        o_result = '0;
        case (r_f3)
            FUNCT3_MD_MUL:                      o_result = w_prod_res[XLEN-1:0];
            FUNCT3_MD_MULH, FUNCT3_MD_MULHSU,
            FUNCT3_MD_MULHU:                    o_result = w_prod_res[2*XLEN-1:XLEN];
            FUNCT3_MD_DIV, FUNCT3_MD_DIVU:      o_result = r_neg_q ? -r_lo : r_lo;
            FUNCT3_MD_REM, FUNCT3_MD_REMU:      o_result = r_neg_r ? -r_hi : r_hi;
            default:                            o_result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_ex_md.sv
// Execute stage: forwarding, ALU, branch/jump resolution and an RV32M unit that stalls
// the front of the pipeline while it iterates. Optional macro: RISCV_EX_FAST_MUL_EN.
module riscv_ex_md
    import riscv_ex_md_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned N_FWD_SRC = 3,
    parameter int unsigned FWD_SEL_W = $clog2(N_FWD_SRC)
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_ex_valid,
    input  logic                 i_ex_flush,
    input  logic [1:0]           i_ex_ctrl_jump,
    input  logic                 i_ex_ctrl_branch,
    input  logic                 i_ex_ctrl_alu_b_src,
    input  logic                 i_ex_ctrl_md,
    input  logic [3:0]           i_ex_ctrl_alu_ctrl,
    input  logic [2:0]           i_ex_funct3,
    input  logic [FWD_SEL_W-1:0] i_ForwardAE,
    input  logic [FWD_SEL_W-1:0] i_ForwardBE,
    input  logic [XLEN-1:0]      i_ex_forward_rd_data,
    input  logic [XLEN-1:0]      i_ex_forward_alu_result,
    input  logic [XLEN-1:0]      i_ex_rs1_data,
    input  logic [XLEN-1:0]      i_ex_rs2_data,
    input  logic [XLEN-1:0]      i_ex_imm,
    input  logic [XLEN-1:0]      i_ex_pc,
    output logic [XLEN-1:0]      o_ex_result,
    output logic [XLEN-1:0]      o_ex_write_data,
    output logic [XLEN-1:0]      o_ex_pc_plus_imm,
    output logic [1:0]           o_ex_ctrl_pc_src,
    output logic                 o_ex_stall,
    output logic                 o_ex_md_busy
);
    localparam int unsigned SH_W = $clog2(XLEN);

    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_result, w_md_result;
    logic            w_taken, w_md_start, w_md_stall, w_md_done;

    always_comb begin
        w_fwd_a = i_ex_rs1_data;
        case (i_ForwardAE)
            FWD_SEL_W'(FWD_SEL_RF):  w_fwd_a = i_ex_rs1_data;
            FWD_SEL_W'(FWD_SEL_WB):  w_fwd_a = i_ex_forward_rd_data;
            FWD_SEL_W'(FWD_SEL_MEM): w_fwd_a = i_ex_forward_alu_result;
            default:                 w_fwd_a = i_ex_rs1_data;
        endcase
    end

    always_comb begin
        w_fwd_b = i_ex_rs2_data;
        case (i_ForwardBE)
            FWD_SEL_W'(FWD_SEL_RF):  w_fwd_b = i_ex_rs2_data;
            FWD_SEL_W'(FWD_SEL_WB):  w_fwd_b = i_ex_forward_rd_data;
            FWD_SEL_W'(FWD_SEL_MEM): w_fwd_b = i_ex_forward_alu_result;
            default:                 w_fwd_b = i_ex_rs2_data;
        endcase
    end

    assign w_alu_b          = i_ex_ctrl_alu_b_src ? i_ex_imm : w_fwd_b;
    assign o_ex_write_data  = w_fwd_b;
    assign o_ex_pc_plus_imm = i_ex_pc + i_ex_imm;

    always_comb begin
        w_alu_result = '0;
        case (i_ex_ctrl_alu_ctrl)
            ALU_ADD:   w_alu_result = w_fwd_a + w_alu_b;
            ALU_SUB:   w_alu_result = w_fwd_a - w_alu_b;
            ALU_SLL:   w_alu_result = w_fwd_a << w_alu_b[SH_W-1:0];
            ALU_SLT:   w_alu_result = XLEN'($signed(w_fwd_a) < $signed(w_alu_b));
            ALU_SLTU:  w_alu_result = XLEN'(w_fwd_a < w_alu_b);
            ALU_XOR:   w_alu_result = w_fwd_a ^ w_alu_b;
            ALU_SRL:   w_alu_result = w_fwd_a >> w_alu_b[SH_W-1:0];
            ALU_SRA:   w_alu_result = $unsigned($signed(w_fwd_a) >>> w_alu_b[SH_W-1:0]);
            ALU_OR:    w_alu_result = w_fwd_a | w_alu_b;
            ALU_AND:   w_alu_result = w_fwd_a & w_alu_b;
            ALU_PASSB: w_alu_result = w_alu_b;
            default:   w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (i_ex_funct3)
            FUNCT3_BEQ:  w_taken = (w_fwd_a == w_fwd_b);
            FUNCT3_BNE:  w_taken = (w_fwd_a != w_fwd_b);
            FUNCT3_BLT:  w_taken = ($signed(w_fwd_a) < $signed(w_fwd_b));
            FUNCT3_BGE:  w_taken = !($signed(w_fwd_a) < $signed(w_fwd_b));
            FUNCT3_BLTU: w_taken = (w_fwd_a < w_fwd_b);
            FUNCT3_BGEU: w_taken = !(w_fwd_a < w_fwd_b);
            default:     w_taken = 1'b0;
        endcase
    end

    // Redirects are suppressed while the MD unit holds the instruction in EX.
    always_comb begin
        o_ex_ctrl_pc_src = PC_SRC_PC4;
        if (i_ex_ctrl_branch && w_taken)       o_ex_ctrl_pc_src = PC_SRC_IMM;
        else if (i_ex_ctrl_jump == JUMP_JAL)   o_ex_ctrl_pc_src = PC_SRC_IMM;
        else if (i_ex_ctrl_jump == JUMP_JALR)  o_ex_ctrl_pc_src = PC_SRC_JALR;
        if (!i_ex_valid || w_md_stall)         o_ex_ctrl_pc_src = PC_SRC_PC4;
    end

    assign w_md_start = i_ex_valid & i_ex_ctrl_md & ~i_ex_flush;

    riscv_ex_md_md_unit #(
        .XLEN (XLEN)
    ) u_md_unit (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_start  (w_md_start),
        .i_flush  (i_ex_flush),
        .i_funct3 (i_ex_funct3),
        .i_a      (w_fwd_a),
        .i_b      (w_fwd_b),
        .o_stall  (w_md_stall),
        .o_busy   (o_ex_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    assign o_ex_stall  = w_md_stall;
    assign o_ex_result = w_md_done ? w_md_result : w_alu_result;

endmodule

// File: tb/tb_riscv_ex_md.sv
// Directed self-checking bench for riscv_ex_md (XLEN = 32) with hand-computed vectors.
module tb_riscv_ex_md;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned FWD_SEL_W = 2;

`ifdef RISCV_EX_FAST_MUL_EN
    localparam int MUL_STALLS = 1;
`else
    localparam int MUL_STALLS = 33;
`endif

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 i_ex_valid, i_ex_flush, i_ex_ctrl_branch, i_ex_ctrl_alu_b_src, i_ex_ctrl_md;
    logic [1:0]           i_ex_ctrl_jump;
    logic [3:0]           i_ex_ctrl_alu_ctrl;
    logic [2:0]           i_ex_funct3;
    logic [FWD_SEL_W-1:0] i_ForwardAE, i_ForwardBE;
    logic [XLEN-1:0]      i_ex_forward_rd_data, i_ex_forward_alu_result;
    logic [XLEN-1:0]      i_ex_rs1_data, i_ex_rs2_data, i_ex_imm, i_ex_pc;
    logic [XLEN-1:0]      o_ex_result, o_ex_write_data, o_ex_pc_plus_imm;
    logic [1:0]           o_ex_ctrl_pc_src;
    logic                 o_ex_stall, o_ex_md_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    riscv_ex_md #(
        .XLEN      (XLEN),
        .N_FWD_SRC (3),
        .FWD_SEL_W (FWD_SEL_W)
    ) u_dut (
        .i_clk                   (clk),
        .i_rstn                  (rstn),
        .i_ex_valid              (i_ex_valid),
        .i_ex_flush              (i_ex_flush),
        .i_ex_ctrl_jump          (i_ex_ctrl_jump),
        .i_ex_ctrl_branch        (i_ex_ctrl_branch),
        .i_ex_ctrl_alu_b_src     (i_ex_ctrl_alu_b_src),
        .i_ex_ctrl_md            (i_ex_ctrl_md),
        .i_ex_ctrl_alu_ctrl      (i_ex_ctrl_alu_ctrl),
        .i_ex_funct3             (i_ex_funct3),
        .i_ForwardAE             (i_ForwardAE),
        .i_ForwardBE             (i_ForwardBE),
        .i_ex_forward_rd_data    (i_ex_forward_rd_data),
        .i_ex_forward_alu_result (i_ex_forward_alu_result),
        .i_ex_rs1_data           (i_ex_rs1_data),
        .i_ex_rs2_data           (i_ex_rs2_data),
        .i_ex_imm                (i_ex_imm),
        .i_ex_pc                 (i_ex_pc),
        .o_ex_result             (o_ex_result),
        .o_ex_write_data         (o_ex_write_data),
        .o_ex_pc_plus_imm        (o_ex_pc_plus_imm),
        .o_ex_ctrl_pc_src        (o_ex_ctrl_pc_src),
        .o_ex_stall              (o_ex_stall),
        .o_ex_md_busy            (o_ex_md_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic nop();
        i_ex_valid = 1'b0;  i_ex_flush = 1'b0;  i_ex_ctrl_jump = 2'b00;
        i_ex_ctrl_branch = 1'b0;  i_ex_ctrl_alu_b_src = 1'b0;  i_ex_ctrl_md = 1'b0;
        i_ex_ctrl_alu_ctrl = OP_ADD;  i_ex_funct3 = 3'b000;
        i_ForwardAE = '0;  i_ForwardBE = '0;
        i_ex_forward_rd_data = '0;  i_ex_forward_alu_result = '0;
        i_ex_rs1_data = '0;  i_ex_rs2_data = '0;  i_ex_imm = '0;  i_ex_pc = '0;
    endtask

    // Issue one MD op, count stall cycles (bounded), check the DONE-cycle result.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stalls, input logic [31:0] exp_res);
        int stalls = 0;
        nop();
        i_ex_valid = 1'b1;  i_ex_ctrl_md = 1'b1;  i_ex_funct3 = f3;
        i_ex_ctrl_jump = 2'b01;
        i_ex_rs1_data = a;  i_ex_rs2_data = b;
        #1;
        check({tag, " pc_src during stall"}, 32'(o_ex_ctrl_pc_src), 32'd0);
        while (o_ex_stall && stalls < 100) begin
            stalls++;
            @(posedge clk); #1;
            i_ex_rs1_data = 32'hDEAD_BEEF;
            i_ex_rs2_data = 32'h0000_0001;
            #1;
        end
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, " result"}, o_ex_result, exp_res);
        @(posedge clk); #1;
        nop();
        #1;
    endtask

    initial begin
        nop();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(o_ex_stall), 32'd0);
        check("reset busy", 32'(o_ex_md_busy), 32'd0);
        check("reset result", o_ex_result, 32'd0);
        rstn = 1'b1;

        // ADD with rs1 forwarded from MEM
        nop();
        i_ex_valid = 1'b1;  i_ForwardAE = 2'd2;  i_ex_forward_alu_result = 32'd5;
        i_ex_rs1_data = 32'h100;  i_ex_rs2_data = 32'd7;
        @(negedge clk);
        check("add result", o_ex_result, 32'd12);
        check("add stall", 32'(o_ex_stall), 32'd0);
        check("add pc_src", 32'(o_ex_ctrl_pc_src), 32'd0);

        // SUB with rs2 forwarded from WB; store data follows forwarded rs2
        nop();
        i_ex_valid = 1'b1;  i_ForwardBE = 2'd1;  i_ex_forward_rd_data = 32'd30;
        i_ex_rs1_data = 32'd100;  i_ex_rs2_data = 32'd999;  i_ex_ctrl_alu_ctrl = OP_SUB;
        @(negedge clk);
        check("sub result", o_ex_result, 32'd70);
        check("store data", o_ex_write_data, 32'd30);

        // Branches
        nop();
        i_ex_valid = 1'b1;  i_ex_ctrl_branch = 1'b1;  i_ex_funct3 = 3'b100;
        i_ex_rs1_data = 32'hFFFF_FFFF;  i_ex_rs2_data = 32'd1;
        i_ex_pc = 32'h0000_1000;  i_ex_imm = 32'h0000_0020;
        @(negedge clk);
        check("blt pc_src", 32'(o_ex_ctrl_pc_src), 32'd1);
        check("branch target", o_ex_pc_plus_imm, 32'h0000_1020);
        i_ex_funct3 = 3'b110;
        @(negedge clk);
        check("bltu pc_src", 32'(o_ex_ctrl_pc_src), 32'd0);
        i_ex_funct3 = 3'b111;
        @(negedge clk);
        check("bgeu pc_src", 32'(o_ex_ctrl_pc_src), 32'd1);
        i_ex_valid = 1'b0;
        @(negedge clk);
        check("invalid pc_src", 32'(o_ex_ctrl_pc_src), 32'd0);
        i_ex_valid = 1'b1;  i_ex_funct3 = 3'b011;
        @(negedge clk);
        check("bad funct3 pc_src", 32'(o_ex_ctrl_pc_src), 32'd0);

        // JALR: target rs1+imm on the ALU
        nop();
        i_ex_valid = 1'b1;  i_ex_ctrl_jump = 2'b10;  i_ex_ctrl_alu_b_src = 1'b1;
        i_ex_rs1_data = 32'h0000_2000;  i_ex_imm = 32'd4;
        @(negedge clk);
        check("jalr pc_src", 32'(o_ex_ctrl_pc_src), 32'd2);
        check("jalr target", o_ex_result, 32'h0000_2004);

        // Multiply / divide
        run_md("mul", 3'b000, 32'hFFFF_FFFF, 32'd3, MUL_STALLS, 32'hFFFF_FFFD);
        run_md("mulhu", 3'b011, 32'hFFFF_FFFF, 32'd3, MUL_STALLS, 32'h0000_0002);
        run_md("mulh", 3'b001, 32'd2, 32'h8000_0000, MUL_STALLS, 32'hFFFF_FFFF);
        run_md("mulhsu", 3'b010, 32'd2, 32'h8000_0000, MUL_STALLS, 32'h0000_0001);
        run_md("div neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_md("rem neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_md("div by zero", 3'b100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_md("rem by zero", 3'b110, 32'd5, 32'd0, 1, 32'd5);
        run_md("div overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_md("rem overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // Flush at BUSY count 10, then a plain ADDI
        nop();
        i_ex_valid = 1'b1;  i_ex_ctrl_md = 1'b1;  i_ex_funct3 = 3'b000;
        i_ex_rs1_data = 32'd7;  i_ex_rs2_data = 32'd9;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        check("busy before flush", 32'(o_ex_stall), 32'd1);
        i_ex_flush = 1'b1;
        #1;
        check("flush stall drop", 32'(o_ex_stall), 32'd0);
        @(posedge clk); #1;
        check("flush to idle", 32'(o_ex_md_busy), 32'd0);
        nop();
        i_ex_valid = 1'b1;  i_ex_ctrl_alu_b_src = 1'b1;
        i_ex_rs1_data = 32'd100;  i_ex_imm = 32'd23;
        #1;
        check("addi after flush", o_ex_result, 32'd123);
        check("addi stall", 32'(o_ex_stall), 32'd0);
        @(posedge clk); #1;
        check("addi no busy", 32'(o_ex_md_busy), 32'd0);

        // Reset in the middle of a divide
        nop();
        i_ex_valid = 1'b1;  i_ex_ctrl_md = 1'b1;  i_ex_funct3 = 3'b101;
        i_ex_rs1_data = 32'd100;  i_ex_rs2_data = 32'd7;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        check("busy before reset", 32'(o_ex_md_busy), 32'd1);
        rstn = 1'b0;
        nop();
        #1;
        check("mid reset stall", 32'(o_ex_stall), 32'd0);
        check("mid reset busy", 32'(o_ex_md_busy), 32'd0);
        check("mid reset result", o_ex_result, 32'd0);
        check("mid reset pc_src", 32'(o_ex_ctrl_pc_src), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        run_md("divu", 3'b101, 32'd100, 32'd7, 33, 32'd14);
        run_md("remu", 3'b111, 32'd100, 32'd7, 33, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
